ibex_rf_wport_sched: RTL and testbench

- Write-port scheduler for the integer register file.
- Shares the register file's single write port between two requesters and owns a clear sequencer:
  - core writeback
  - debug-module register writes
- The clear sequencer zeroes x1..x(NUM_WORDS-1) on request.
- Sits between the ID/WB stage plus the debug module on one side and the register file write port (waddr/wdata/we) on the other.

---
 rtl/ibex_rf_wport_sched.sv | 114 +++++++++++
 tb/tb_ibex_rf_wport_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_rf_wport_sched.sv
// Register file write-port scheduler: arbitrates core writeback against debug writes and runs a clear sequence.
// Define IBEX_RF_CLEAR_ON_RESET_EN to start a clear sequence automatically when reset is released.
module ibex_rf_wport_sched #(
  parameter bit          RV32E      = 1'b0,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned DbgMaxWait = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_req_i,
  output logic                 clear_busy_o,
  output logic                 clear_done_o,
  input  logic                 wb_we_i,
  input  logic [4:0]           wb_waddr_i,
  input  logic [DataWidth-1:0] wb_wdata_i,
  output logic                 wb_gnt_o,
  input  logic                 dbg_req_i,
  input  logic [4:0]           dbg_waddr_i,
  input  logic [DataWidth-1:0] dbg_wdata_i,
  output logic                 dbg_gnt_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 illegal_waddr_o
);

  localparam int unsigned NumWords = RV32E ? 16 : 32;
  localparam logic [4:0]  LastAddr = 5'(NumWords - 1);
  localparam logic [3:0]  MaxWait  = 4'(DbgMaxWait);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e         state_q;
  logic [3:0]     wait_cnt_q;
  logic [4:0]     seq_addr_q;

  logic           arb_en;
  logic           forced;
  logic           any_gnt;
  logic [4:0]     gnt_addr;
  logic [DataWidth-1:0] gnt_data;
  logic           addr_illegal;

  // A pending clear request blocks both requesters in the cycle it is accepted.
  assign arb_en    = (state_q == IDLE) & ~clear_req_i;
  assign forced    = dbg_req_i & (wait_cnt_q == MaxWait);
  assign wb_gnt_o  = arb_en & wb_we_i & ~forced;
  assign dbg_gnt_o = arb_en & dbg_req_i & (~wb_we_i | forced);

  assign any_gnt      = wb_gnt_o | dbg_gnt_o;
  assign gnt_addr     = dbg_gnt_o ? dbg_waddr_i : wb_waddr_i;
  assign gnt_data     = dbg_gnt_o ? dbg_wdata_i : wb_wdata_i;
  assign addr_illegal = RV32E & gnt_addr[4];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef IBEX_RF_CLEAR_ON_RESET_EN
      state_q      <= CLEAR;
      clear_busy_o <= 1'b1;
`else
      state_q      <= IDLE;
      clear_busy_o <= 1'b0;
`endif
      wait_cnt_q      <= 4'd0;
      seq_addr_q      <= 5'd1;
      clear_done_o    <= 1'b0;
      rf_we_o         <= 1'b0;
      rf_waddr_o      <= 5'd0;
      rf_wdata_o      <= '0;
      illegal_waddr_o <= 1'b0;
    end else begin
      rf_we_o         <= 1'b0;
      clear_done_o    <= 1'b0;
      illegal_waddr_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!dbg_req_i || dbg_gnt_o) begin
            wait_cnt_q <= 4'd0;
          end else if (wait_cnt_q != MaxWait) begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
          if (clear_req_i) begin
            state_q      <= CLEAR;
            clear_busy_o <= 1'b1;
          end else if (any_gnt) begin
            // x0 and non-existent registers are accepted but never written.
            rf_we_o         <= (gnt_addr != 5'd0) & ~addr_illegal;
            rf_waddr_o      <= gnt_addr;
            rf_wdata_o      <= gnt_data;
            illegal_waddr_o <= addr_illegal;
          end
        end
        CLEAR: begin
          rf_we_o    <= 1'b1;
          rf_waddr_o <= seq_addr_q;
          rf_wdata_o <= '0;
          if (seq_addr_q == LastAddr) begin
            clear_done_o <= 1'b1;
            clear_busy_o <= 1'b0;
            state_q      <= IDLE;
            seq_addr_q   <= 5'd1;
          end else begin
            seq_addr_q <= seq_addr_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_rf_wport_sched.sv
// Directed bench for ibex_rf_wport_sched; a second instance with RV32E=1 shares the stimulus.
module tb_ibex_rf_wport_sched;

`ifdef IBEX_RF_CLEAR_ON_RESET_EN
  localparam bit ClrOnRst = 1'b1;
`else
  localparam bit ClrOnRst = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        clear_req_i;
  logic        wb_we_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        dbg_req_i;
  logic [4:0]  dbg_waddr_i;
  logic [31:0] dbg_wdata_i;

  logic        clear_busy, clear_done, wb_gnt, dbg_gnt, rf_we, illegal;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        clear_busy_e, clear_done_e, wb_gnt_e, dbg_gnt_e, rf_we_e, illegal_e;
  logic [4:0]  rf_waddr_e;
  logic [31:0] rf_wdata_e;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done;

  always #5 clk_i = ~clk_i;

  ibex_rf_wport_sched #(.RV32E(1'b0), .DataWidth(32), .DbgMaxWait(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_req_i(clear_req_i),
    .clear_busy_o(clear_busy), .clear_done_o(clear_done),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .wb_gnt_o(wb_gnt),
    .dbg_req_i(dbg_req_i), .dbg_waddr_i(dbg_waddr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .illegal_waddr_o(illegal)
  );

  ibex_rf_wport_sched #(.RV32E(1'b1), .DataWidth(32), .DbgMaxWait(4)) dut_e (
    .clk_i(clk_i), .rst_i(rst_i), .clear_req_i(clear_req_i),
    .clear_busy_o(clear_busy_e), .clear_done_o(clear_done_e),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i), .wb_gnt_o(wb_gnt_e),
    .dbg_req_i(dbg_req_i), .dbg_waddr_i(dbg_waddr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_e),
    .rf_we_o(rf_we_e), .rf_waddr_o(rf_waddr_e), .rf_wdata_o(rf_wdata_e), .illegal_waddr_o(illegal_e)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; clear_req_i = 1'b0;
    wb_we_i = 1'b0; wb_waddr_i = 5'd0; wb_wdata_i = 32'd0;
    dbg_req_i = 1'b0; dbg_waddr_i = 5'd0; dbg_wdata_i = 32'd0;
    step(); step();

    check("rst_busy",    64'(clear_busy), 64'(ClrOnRst));
    check("rst_done",    64'(clear_done), 64'd0);
    check("rst_rf_we",   64'(rf_we),      64'd0);
    check("rst_waddr",   64'(rf_waddr),   64'd0);
    check("rst_wdata",   64'(rf_wdata),   64'd0);
    check("rst_illegal", 64'(illegal),    64'd0);

    rst_i = 1'b0;
`ifdef IBEX_RF_CLEAR_ON_RESET_EN
    wb_we_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = 32'h33;
    for (int i = 0; i < 31; i++) begin
      check($sformatf("por_clear_gnt%0d", i), 64'(wb_gnt), 64'd0);
      step();
    end
    check("por_after_gnt", 64'(wb_gnt), 64'd1);
    check("por_last_addr", 64'(rf_waddr), 64'd31);
    check("por_done",      64'(clear_done), 64'd1);
    wb_we_i = 1'b0;
    step(); step();
`else
    step();
`endif

    // Core-only write
    wb_we_i = 1'b1; wb_waddr_i = 5'd5; wb_wdata_i = 32'hDEADBEEF;
    #1;
    check("core_wb_gnt",  64'(wb_gnt),  64'd1);
    check("core_dbg_gnt", 64'(dbg_gnt), 64'd0);
    step();
    wb_we_i = 1'b0;
    check("core_rf_we",    64'(rf_we),    64'd1);
    check("core_rf_waddr", 64'(rf_waddr), 64'd5);
    check("core_rf_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    step();
    check("core_idle_we",   64'(rf_we),    64'd0);
    check("core_hold_addr", 64'(rf_waddr), 64'd5);

    // Contention: debug loses four times, then is forced through
    wb_we_i = 1'b1; wb_waddr_i = 5'd9; wb_wdata_i = 32'hAAAA;
    dbg_req_i = 1'b1; dbg_waddr_i = 5'd7; dbg_wdata_i = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont_wb_gnt%0d", i),  64'(wb_gnt),  64'd1);
      check($sformatf("cont_dbg_gnt%0d", i), 64'(dbg_gnt), 64'd0);
      step();
    end
    check("cont_forced_dbg", 64'(dbg_gnt), 64'd1);
    check("cont_forced_wb",  64'(wb_gnt),  64'd0);
    step();
    dbg_req_i = 1'b0;
    #1;
    check("cont_rf_waddr", 64'(rf_waddr), 64'd7);
    check("cont_rf_wdata", 64'(rf_wdata), 64'h1234);
    check("cont_rf_we",    64'(rf_we),    64'd1);
    dbg_req_i = 1'b1;
    #1;
    check("cont_cnt_reset_wb",  64'(wb_gnt),  64'd1);
    check("cont_cnt_reset_dbg", 64'(dbg_gnt), 64'd0);
    dbg_req_i = 1'b0; wb_we_i = 1'b0;
    step(); step();

    // Clear request beats a same-cycle writeback, which is then held until the clear ends
    clear_req_i = 1'b1; wb_we_i = 1'b1; wb_waddr_i = 5'd12; wb_wdata_i = 32'h5;
    #1;
    check("clr_req_wb_gnt", 64'(wb_gnt), 64'd0);
    step();
    clear_req_i = 1'b0;
    check("clr_busy", 64'(clear_busy), 64'd1);
    for (int k = 1; k <= 31; k++) begin
      step();
      check($sformatf("clr_we%0d", k),    64'(rf_we),      64'd1);
      check($sformatf("clr_addr%0d", k),  64'(rf_waddr),   64'(k));
      check($sformatf("clr_data%0d", k),  64'(rf_wdata),   64'd0);
      check($sformatf("clr_done%0d", k),  64'(clear_done), 64'(k == 31));
      check($sformatf("clr_wbgnt%0d", k), 64'(wb_gnt),     64'(k == 31));
    end
    step();
    wb_we_i = 1'b0;
    check("clr_post_we",   64'(rf_we),      64'd1);
    check("clr_post_addr", 64'(rf_waddr),   64'd12);
    check("clr_post_data", 64'(rf_wdata),   64'h5);
    check("clr_post_done", 64'(clear_done), 64'd0);
    check("clr_post_busy", 64'(clear_busy), 64'd0);
    step();

    // x0 is granted but never written
    wb_we_i = 1'b1; wb_waddr_i = 5'd0; wb_wdata_i = 32'h7;
    #1;
    check("x0_gnt", 64'(wb_gnt), 64'd1);
    step();
    wb_we_i = 1'b0;
    check("x0_rf_we", 64'(rf_we), 64'd0);
    step();

    // Address 17 is illegal only on the RV32E instance
    wb_we_i = 1'b1; wb_waddr_i = 5'd17; wb_wdata_i = 32'h17;
    #1;
    check("e_gnt", 64'(wb_gnt_e), 64'd1);
    step();
    wb_we_i = 1'b0;
    check("e_rf_we",    64'(rf_we_e),   64'd0);
    check("e_illegal",  64'(illegal_e), 64'd1);
    check("i_rf_we",    64'(rf_we),     64'd1);
    check("i_rf_waddr", 64'(rf_waddr),  64'd17);
    check("i_illegal",  64'(illegal),   64'd0);
    step();
    check("e_illegal_pulse", 64'(illegal_e), 64'd0);

`ifndef IBEX_RF_CLEAR_ON_RESET_EN
    // Reset in the middle of a clear aborts it without a done pulse
    clear_req_i = 1'b1;
    step();
    clear_req_i = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check("abort_addr10", 64'(rf_waddr), 64'd10);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("abort_rf_we", 64'(rf_we),      64'd0);
    check("abort_busy",  64'(clear_busy), 64'd0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (clear_done === 1'b1 || rf_we === 1'b1) n_done++;
    end
    check("abort_no_activity", 64'(n_done), 64'd0);
    clear_req_i = 1'b1;
    step();
    clear_req_i = 1'b0;
    step();
    check("restart_addr", 64'(rf_waddr), 64'd1);
    check("restart_we",   64'(rf_we),    64'd1);
    for (int k = 0; k < 32; k++) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
